// File: rtl/regfile_lane_alu_ctrl_pkg.sv
// Shared definitions for the lane ALU controller and the 4x512 register file it drives.
package regfile_lane_alu_ctrl_pkg;

   localparam int RF_ADDR_W = 2;
   localparam int RF_DATA_W = 512;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_EXEC  = 3'd2,
      S_WR_LO = 3'd3,
      S_WR_HI = 3'd4,
      S_DONE  = 3'd5
   } state_e;

endpackage

// File: rtl/regfile_lane_alu_ctrl_lane_alu_slice.sv
// Combinational signed ALU over LANES lanes; MUL returns the full double-width product split lo/hi.
module lane_alu_slice
   import regfile_lane_alu_ctrl_pkg::*;
#(
   parameter int LANE_W = 32,
   parameter int LANES  = 4
) (
   input  logic [1:0]              op_i,
   input  logic [LANES*LANE_W-1:0] a_i,
   input  logic [LANES*LANE_W-1:0] b_i,
   output logic [LANES*LANE_W-1:0] lo_o,
   output logic [LANES*LANE_W-1:0] hi_o
);

   logic signed [LANE_W-1:0]   a_l;
   logic signed [LANE_W-1:0]   b_l;
   logic signed [2*LANE_W-1:0] prod;

   always_comb begin
      lo_o = '0;
      hi_o = '0;
      a_l  = '0;
      b_l  = '0;
      prod = '0;
      for (int l = 0; l < LANES; l++) begin
         a_l  = a_i[l*LANE_W +: LANE_W];
         b_l  = b_i[l*LANE_W +: LANE_W];
         prod = a_l * b_l;
         case (op_i)
            OP_ADD:  lo_o[l*LANE_W +: LANE_W] = a_l + b_l;
            OP_SUB:  lo_o[l*LANE_W +: LANE_W] = a_l - b_l;
            OP_MUL: begin
               lo_o[l*LANE_W +: LANE_W] = prod[LANE_W-1:0];
               hi_o[l*LANE_W +: LANE_W] = prod[2*LANE_W-1:LANE_W];
            end
            default: lo_o[l*LANE_W +: LANE_W] = '0;
         endcase
      end
   end

endmodule

// File: rtl/regfile_lane_alu_ctrl.sv
// Register-file client: reads two operands, runs a lane-wise ALU op a slice per cycle, writes back.
// Handshake: start is a one-cycle command strobe, taken only when busy is low; done/err pulse once.
module regfile_lane_alu_ctrl
   import regfile_lane_alu_ctrl_pkg::*;
#(
   parameter int DATA_W          = RF_DATA_W,
   parameter int LANE_W          = 32,
   parameter int LANES_PER_CYCLE = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [1:0]           opcode,
   input  logic [RF_ADDR_W-1:0] src_a,
   input  logic [RF_ADDR_W-1:0] src_b,
   input  logic [RF_ADDR_W-1:0] dst_lo,
   input  logic [RF_ADDR_W-1:0] dst_hi,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [RF_ADDR_W-1:0] rf_read_a_addr,
   output logic [RF_ADDR_W-1:0] rf_read_b_addr,
   input  logic [DATA_W-1:0]    rf_data_a,
   input  logic [DATA_W-1:0]    rf_data_b,
   output logic [RF_ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0]    rf_write_data,
   output logic                 rf_write_en,
   output state_e               dbg_state_o
);

   localparam int NUM_LANES = DATA_W / LANE_W;
   localparam int EXEC_CYC  = NUM_LANES / LANES_PER_CYCLE;
   localparam int SLICE_W   = LANES_PER_CYCLE * LANE_W;
   localparam int CNT_W     = (EXEC_CYC > 1) ? $clog2(EXEC_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYC - 1);

   state_e                 state_q, state_d;
   logic [1:0]             opcode_q, opcode_d;
   logic [RF_ADDR_W-1:0]   src_a_q, src_a_d, src_b_q, src_b_d;
   logic [RF_ADDR_W-1:0]   dst_lo_q, dst_lo_d, dst_hi_q, dst_hi_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [DATA_W-1:0]      op_a_q, op_a_d, op_b_q, op_b_d;
   logic [DATA_W-1:0]      res_lo_q, res_lo_d, res_hi_q, res_hi_d;
   logic                   err_q, err_d;
   logic [SLICE_W-1:0]     slice_a, slice_b, slice_lo, slice_hi;

   assign slice_a = op_a_q[int'(cnt_q)*SLICE_W +: SLICE_W];
   assign slice_b = op_b_q[int'(cnt_q)*SLICE_W +: SLICE_W];

   lane_alu_slice #(
      .LANE_W (LANE_W),
      .LANES  (LANES_PER_CYCLE)
   ) u_slice (
      .op_i (opcode_q),
      .a_i  (slice_a),
      .b_i  (slice_b),
      .lo_o (slice_lo),
      .hi_o (slice_hi)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         opcode_q <= '0;
         src_a_q  <= '0;
         src_b_q  <= '0;
         dst_lo_q <= '0;
         dst_hi_q <= '0;
         cnt_q    <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         src_a_q  <= src_a_d;
         src_b_q  <= src_b_d;
         dst_lo_q <= dst_lo_d;
         dst_hi_q <= dst_hi_d;
         cnt_q    <= cnt_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      src_a_d  = src_a_q;
      src_b_d  = src_b_q;
      dst_lo_d = dst_lo_q;
      dst_hi_d = dst_hi_q;
      cnt_d    = cnt_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      err_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A rejected command leaves the previous read addresses untouched.
            if (start) begin
               if (opcode == OP_RSV) begin
                  err_d = 1'b1;
               end else begin
                  opcode_d = opcode;
                  src_a_d  = src_a;
                  src_b_d  = src_b;
                  dst_lo_d = dst_lo;
                  dst_hi_d = dst_hi;
                  state_d  = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            op_a_d  = rf_data_a;
            op_b_d  = rf_data_b;
            cnt_d   = '0;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            res_lo_d[int'(cnt_q)*SLICE_W +: SLICE_W] = slice_lo;
            res_hi_d[int'(cnt_q)*SLICE_W +: SLICE_W] = slice_hi;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = S_WR_LO;
         end
         S_WR_LO: state_d = (opcode_q == OP_MUL) ? S_WR_HI : S_DONE;
         S_WR_HI: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rf_write_en   = 1'b0;
      rf_write_addr = '0;
      rf_write_data = '0;
      if (state_q == S_WR_LO) begin
         rf_write_en   = 1'b1;
         rf_write_addr = dst_lo_q;
         rf_write_data = res_lo_q;
      end else if (state_q == S_WR_HI) begin
         rf_write_en   = 1'b1;
         rf_write_addr = dst_hi_q;
         rf_write_data = res_hi_q;
      end
   end

   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign err            = err_q;
   assign rf_read_a_addr = src_a_q;
   assign rf_read_b_addr = src_b_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_regfile_lane_alu_ctrl.sv
// Directed bench: the controller paired with a behavioural 4x512 register file.
module tb_regfile_lane_alu_ctrl;
   import regfile_lane_alu_ctrl_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   opcode = '0;
   logic [1:0]   src_a = '0, src_b = '0, dst_lo = '0, dst_hi = '0;
   logic         busy, done, err;
   logic [1:0]   rf_read_a_addr, rf_read_b_addr, rf_write_addr;
   logic [511:0] rf_data_a, rf_data_b, rf_write_data;
   logic         rf_write_en;
   state_e       dbg_state;

   logic [511:0] rf [4];
   logic         pre_en = 1'b0;
   logic [1:0]   pre_addr = '0;
   logic [511:0] pre_data = '0;
   int           total_wr = 0;
   int           checks = 0;
   int           errors = 0;

   regfile_lane_alu_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .opcode         (opcode),
      .src_a          (src_a),
      .src_b          (src_b),
      .dst_lo         (dst_lo),
      .dst_hi         (dst_hi),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .rf_read_a_addr (rf_read_a_addr),
      .rf_read_b_addr (rf_read_b_addr),
      .rf_data_a      (rf_data_a),
      .rf_data_b      (rf_data_b),
      .rf_write_addr  (rf_write_addr),
      .rf_write_data  (rf_write_data),
      .rf_write_en    (rf_write_en),
      .dbg_state_o    (dbg_state)
   );

   always #5 clk = ~clk;

   assign rf_data_a = rf[rf_read_a_addr];
   assign rf_data_b = rf[rf_read_b_addr];

   always @(posedge clk) begin
      if (pre_en) rf[pre_addr] <= pre_data;
      else if (rf_write_en) begin
         rf[rf_write_addr] <= rf_write_data;
         total_wr <= total_wr + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "timeout");
   end

   function automatic logic [511:0] splat(input logic [31:0] v);
      return {16{v}};
   endfunction

   task automatic preload(input logic [1:0] a, input logic [511:0] d);
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   task automatic issue(input logic [1:0] op, input logic [1:0] sa, input logic [1:0] sb,
                        input logic [1:0] dl, input logic [1:0] dh);
      start = 1'b1; opcode = op; src_a = sa; src_b = sb; dst_lo = dl; dst_hi = dh;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Called in cycle 1 after the accept edge; returns the cycle in which done is seen (-1 on timeout).
   task automatic wait_done(input int poke_k, output int k_done, output int n_wr,
                            output int first_wr, output int last_wr);
      k_done = -1; n_wr = 0; first_wr = -1; last_wr = -1;
      for (int k = 1; k <= 20; k++) begin
         if (rf_write_en) begin
            n_wr++;
            if (first_wr < 0) first_wr = k;
            last_wr = k;
         end
         if (done) begin
            k_done = k;
            return;
         end
         if (k == poke_k) begin
            start = 1'b1; opcode = OP_SUB; src_a = 2'd0; src_b = 2'd0; dst_lo = 2'd0; dst_hi = 2'd0;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   task automatic test_reset;
      #2;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b%b want 00", done, err); end
      checks++; if (rf_write_en !== 1'b0 || rf_write_addr !== 2'd0 || rf_write_data !== '0) begin
         errors++; $display("FAIL reset_write_port: en %b addr %0d want 0/0/0", rf_write_en, rf_write_addr); end
      checks++; if (rf_read_a_addr !== 2'd0 || rf_read_b_addr !== 2'd0 || dbg_state !== S_IDLE) begin
         errors++; $display("FAIL reset_read_state: a %0d b %0d st %0d want 0 0 0", rf_read_a_addr, rf_read_b_addr, dbg_state); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add;
      int kd, nw, fw, lw;
      preload(2'd0, splat(32'h7FFF_FFFF));
      preload(2'd1, splat(32'h0000_0001));
      preload(2'd2, '0);
      issue(OP_ADD, 2'd0, 2'd1, 2'd2, 2'd3);
      checks++; if (busy !== 1'b1 || rf_read_a_addr !== 2'd0 || rf_read_b_addr !== 2'd1) begin
         errors++; $display("FAIL add_load: busy %b a %0d b %0d want 1 0 1", busy, rf_read_a_addr, rf_read_b_addr); end
      wait_done(0, kd, nw, fw, lw);
      checks++; if (kd !== 7) begin errors++; $display("FAIL add_latency: got %0d want 7", kd); end
      checks++; if (nw !== 1 || fw !== 6) begin errors++; $display("FAIL add_writes: got %0d at %0d want 1 at 6", nw, fw); end
      @(posedge clk); #1;
      checks++; if (rf[2] !== splat(32'h8000_0000)) begin errors++; $display("FAIL add_result: got %h want 80000000 lanes", rf[2][31:0]); end
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_done_pulse: done %b busy %b want 0 0", done, busy); end
   endtask

   task automatic test_sub;
      int kd, nw, fw, lw;
      logic [511:0] a, b, e;
      for (int i = 0; i < 16; i++) begin
         a[i*32 +: 32] = 32'(i);
         b[i*32 +: 32] = 32'(2*i);
         e[i*32 +: 32] = 32'(0) - 32'(i);
      end
      preload(2'd0, a);
      preload(2'd1, b);
      issue(OP_SUB, 2'd0, 2'd1, 2'd3, 2'd2);
      wait_done(0, kd, nw, fw, lw);
      checks++; if (kd !== 7 || nw !== 1) begin errors++; $display("FAIL sub_timing: done %0d writes %0d want 7 1", kd, nw); end
      @(posedge clk); #1;
      checks++; if (rf[3] !== e) begin errors++; $display("FAIL sub_result: got %h want %h", rf[3][127:0], e[127:0]); end
      checks++; if (rf[3][63:32] !== 32'hFFFF_FFFF || rf[3][511:480] !== 32'hFFFF_FFF1) begin
         errors++; $display("FAIL sub_lanes: lane1 %h lane15 %h want ffffffff fffffff1", rf[3][63:32], rf[3][511:480]); end
   endtask

   task automatic test_mul;
      int kd, nw, fw, lw;
      preload(2'd0, splat(32'hFFFF_FFFF));
      preload(2'd1, splat(32'h0000_0003));
      issue(OP_MUL, 2'd0, 2'd1, 2'd2, 2'd3);
      wait_done(0, kd, nw, fw, lw);
      checks++; if (kd !== 8) begin errors++; $display("FAIL mul_latency: got %0d want 8", kd); end
      checks++; if (nw !== 2 || fw !== 6 || lw !== 7) begin
         errors++; $display("FAIL mul_writes: got %0d writes %0d..%0d want 2 writes 6..7", nw, fw, lw); end
      @(posedge clk); #1;
      checks++; if (rf[2] !== splat(32'hFFFF_FFFD)) begin errors++; $display("FAIL mul_lo: got %h want fffffffd lanes", rf[2][31:0]); end
      checks++; if (rf[3] !== splat(32'hFFFF_FFFF)) begin errors++; $display("FAIL mul_hi: got %h want ffffffff lanes", rf[3][31:0]); end
   endtask

   task automatic test_reserved;
      logic [511:0] snap [4];
      int wr0;
      logic saw_done;
      for (int i = 0; i < 4; i++) snap[i] = rf[i];
      wr0 = total_wr;
      saw_done = 1'b0;
      issue(OP_RSV, 2'd2, 2'd3, 2'd0, 2'd1);
      checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rsv_err: err %b busy %b want 1 0", err, busy); end
      checks++; if (rf_read_a_addr !== 2'd0 || rf_read_b_addr !== 2'd1) begin
         errors++; $display("FAIL rsv_no_read: a %0d b %0d want 0 1", rf_read_a_addr, rf_read_b_addr); end
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (done || busy || err) saw_done = 1'b1;
      end
      checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rsv_quiet: activity %b want 0", saw_done); end
      checks++; if (total_wr !== wr0 || rf[0] !== snap[0] || rf[1] !== snap[1] || rf[2] !== snap[2] || rf[3] !== snap[3]) begin
         errors++; $display("FAIL rsv_rf_unchanged: writes %0d want %0d", total_wr - wr0, 0); end
   endtask

   task automatic test_back_to_back;
      int kd, nw, fw, lw;
      preload(2'd1, splat(32'h0000_0005));
      preload(2'd0, splat(32'h1234_5678));
      issue(OP_ADD, 2'd1, 2'd1, 2'd1, 2'd0);
      wait_done(3, kd, nw, fw, lw);
      checks++; if (kd !== 7 || nw !== 1) begin errors++; $display("FAIL self_add_timing: done %0d writes %0d want 7 1", kd, nw); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midexec_start_ignored: busy %b want 0", busy); end
      checks++; if (rf[1] !== splat(32'h0000_000A) || rf[0] !== splat(32'h1234_5678)) begin
         errors++; $display("FAIL self_add_result: r1 %h r0 %h want 0000000a 12345678", rf[1][31:0], rf[0][31:0]); end
      issue(OP_ADD, 2'd1, 2'd0, 2'd2, 2'd3);
      wait_done(0, kd, nw, fw, lw);
      checks++; if (kd !== 7) begin errors++; $display("FAIL b2b_latency: got %0d want 7", kd); end
      @(posedge clk); #1;
      checks++; if (rf[2] !== splat(32'h1234_5682)) begin errors++; $display("FAIL b2b_result: got %h want 12345682", rf[2][31:0]); end
   endtask

   task automatic test_reset_mid;
      int kd, nw, fw, lw, wr0;
      preload(2'd0, splat(32'hFFFF_FFFF));
      preload(2'd1, splat(32'h0000_0003));
      preload(2'd2, splat(32'hAAAA_AAAA));
      preload(2'd3, splat(32'h5555_5555));
      wr0 = total_wr;
      issue(OP_MUL, 2'd0, 2'd1, 2'd2, 2'd3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (dbg_state !== S_EXEC) begin errors++; $display("FAIL rst_mid_setup: state %0d want %0d", dbg_state, S_EXEC); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || rf_write_en !== 1'b0 || dbg_state !== S_IDLE) begin
         errors++; $display("FAIL rst_mid_outputs: busy %b done %b en %b st %0d want 0 0 0 0", busy, done, rf_write_en, dbg_state); end
      checks++; if (rf_read_a_addr !== 2'd0 || rf_read_b_addr !== 2'd0) begin
         errors++; $display("FAIL rst_mid_addr: a %0d b %0d want 0 0", rf_read_a_addr, rf_read_b_addr); end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      checks++; if (total_wr !== wr0 || rf[2] !== splat(32'hAAAA_AAAA) || rf[3] !== splat(32'h5555_5555)) begin
         errors++; $display("FAIL rst_mid_no_write: writes %0d want 0", total_wr - wr0); end
      issue(OP_ADD, 2'd0, 2'd1, 2'd2, 2'd3);
      wait_done(0, kd, nw, fw, lw);
      checks++; if (kd !== 7 || nw !== 1) begin errors++; $display("FAIL post_rst_timing: done %0d writes %0d want 7 1", kd, nw); end
      @(posedge clk); #1;
      checks++; if (rf[2] !== splat(32'h0000_0002)) begin errors++; $display("FAIL post_rst_result: got %h want 00000002", rf[2][31:0]); end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) rf[i] = '0;
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_reserved();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
